sort_frame_src: RTL and testbench

//  Stimulus transmitter feeding the top-16 sorter input (DataEn/DataIn), replacing file-driven stimulus.
//  - On Start, emits a frame of FrameLen pseudo-random W-bit samples, one every DIV clocks.
//  - Tracks the maximum value sent (RefMax) as a golden check against the sorter's DataMax.
//  - Sits between the control/bench side and the sorter.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_lfsr16.sv | 26 ++
 rtl/sort_frame_src.sv | 130 +++++++++++++
 tb/tb_sort_frame_src.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the top-16 sorter stimulus blocks: LFSR constants,
// frame-source state encoding and the Galois LFSR step function.
package sort_pkg;

   localparam int unsigned SORT_KEEP = 16;
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_DFLT = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 16-bit Galois LFSR, right shift.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sort_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and advance; holds otherwise.
// Load takes priority over advance.
module sort_lfsr16
   import sort_pkg::*;
(
   input  logic        clk,
   input  logic        synrst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] value
);

   // NOTE: sequential state is written with <= only, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!synrst) begin
         value <= LFSR_DFLT;
      end else if (load) begin
         value <= seed;
      end else if (advance) begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/sort_frame_src.sv
// Frame stimulus source for the top-16 sorter: emits FrameLen pseudo-random
// samples one per DIV clocks and tracks the largest value sent.
module sort_frame_src
   import sort_pkg::*;
#(
   parameter int W   = 12,
   parameter int DIV = 2,
   parameter int LW  = 10
) (
   input  logic          clk,
   input  logic          synrst,
   input  logic          Start,
   input  logic          Stop,
   input  logic [15:0]   Seed,
   input  logic [LW-1:0] FrameLen,
   output logic          DataEn,
   output logic [W-1:0]  DataIn,
   output logic          FrameStart,
   output logic          FrameEnd,
   output logic          Busy,
   output logic          Done,
   output logic [W-1:0]  RefMax,
   output logic [LW-1:0] SentCnt
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PACE_LAST = PW'(DIV - 1);

   state_t        state, state_nx;
   logic [PW-1:0] pace, pace_nx;
   logic [LW-1:0] frame_len;
   logic          emit_nx;
   logic          start_ok;
   logic [15:0]   seed_eff;
   logic [15:0]   emit_src;
   logic [15:0]   lfsr_value;

   // The LFSR always holds the next sample to emit, so a registered DataIn can
   // show the seed itself in the first slot after Start.
   assign seed_eff = (Seed == 16'h0000) ? LFSR_DFLT : Seed;
   assign emit_src = start_ok ? seed_eff : lfsr_value;

   sort_lfsr16 u_lfsr (
      .clk     (clk),
      .synrst  (synrst),
      .load    (start_ok),
      .seed    (lfsr_step(seed_eff)),
      .advance (emit_nx),
      .value   (lfsr_value)
   );

   assign FrameStart = DataEn && (SentCnt == '0);
   assign FrameEnd   = DataEn && (SentCnt == frame_len - LW'(1));

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      pace_nx  = pace;
      emit_nx  = 1'b0;
      start_ok = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start && !Stop) begin
               start_ok = 1'b1;
               pace_nx  = '0;
               if (FrameLen == '0) begin
                  state_nx = DONE;
               end else begin
                  state_nx = RUN;
                  emit_nx  = 1'b1;
               end
            end
         end
         RUN: begin
            if (Stop) begin
               state_nx = IDLE;
            end else if (FrameEnd) begin
               state_nx = DONE;
            end else begin
               pace_nx = (pace == PACE_LAST) ? '0 : pace + PW'(1);
               emit_nx = (pace_nx == '0);
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!synrst) begin
         state     <= IDLE;
         pace      <= '0;
         frame_len <= '0;
         DataEn    <= 1'b0;
         DataIn    <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         RefMax    <= '0;
         SentCnt   <= '0;
      end else begin
         state  <= state_nx;
         pace   <= pace_nx;
         DataEn <= emit_nx;
         Busy   <= (state_nx == RUN);
         Done   <= (state_nx == DONE);
         if (emit_nx) begin
            DataIn <= emit_src[W-1:0];
         end
         // A sample already on the bus when Stop arrives still counts.
         if (start_ok) begin
            frame_len <= FrameLen;
            RefMax    <= '0;
            SentCnt   <= '0;
         end else if (DataEn) begin
            if (DataIn > RefMax) begin
               RefMax <= DataIn;
            end
            if (SentCnt != '1) begin
               SentCnt <= SentCnt + LW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sort_frame_src.sv
// Directed bench for sort_frame_src: one instance at DIV=1 and one at DIV=2,
// hand-computed LFSR samples, frame markers, Stop/Start corner cases and reset.
module tb_sort_frame_src;

   logic        clk = 1'b0;
   logic        synrst = 1'b0;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] seed = '0;
   logic [9:0]  frame_len = '0;

   logic        en1, fs1, fe1, busy1, done1;
   logic [11:0] din1, rmax1;
   logic [9:0]  cnt1;
   logic        en2, fs2, fe2, busy2, done2;
   logic [11:0] din2, rmax2;
   logic [9:0]  cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sort_frame_src #(.W(12), .DIV(1), .LW(10)) u_div1 (
      .clk(clk), .synrst(synrst), .Start(start1), .Stop(stop), .Seed(seed),
      .FrameLen(frame_len), .DataEn(en1), .DataIn(din1), .FrameStart(fs1),
      .FrameEnd(fe1), .Busy(busy1), .Done(done1), .RefMax(rmax1), .SentCnt(cnt1)
   );

   sort_frame_src #(.W(12), .DIV(2), .LW(10)) u_div2 (
      .clk(clk), .synrst(synrst), .Start(start2), .Stop(stop), .Seed(seed),
      .FrameLen(frame_len), .DataEn(en2), .DataIn(din2), .FrameStart(fs2),
      .FrameEnd(fe2), .Busy(busy2), .Done(done2), .RefMax(rmax2), .SentCnt(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input bit which, input logic [15:0] s, input logic [9:0] len);
      seed      = s;
      frame_len = len;
      if (which) start2 = 1'b1;
      else       start1 = 1'b1;
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [11:0] exp_a [4];
      logic [11:0] exp_c [3];
      logic        done_any;
      logic [15:0] l;
      logic [11:0] m_max, o_max;
      logic [31:0] m_sum, o_sum;
      int          seen;
      bit          got_done;

      exp_a = '{12'h001, 12'h400, 12'hA00, 12'hD00};
      exp_c = '{12'hCE1, 12'h270, 12'h138};

      // Reset state
      tick();
      tick();
      check("rst_en",   en1,   0);
      check("rst_din",  din1,  0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_rmax", rmax1, 0);
      check("rst_cnt",  cnt1,  0);
      check("rst_fs",   fs1,   0);
      check("rst_fe",   fe1,   0);
      synrst = 1'b1;
      tick();

      // Test 1: DIV=1, seed 1, four back-to-back samples
      start_frame(1'b0, 16'h0001, 10'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_en%0d", i),   en1,   1);
         check($sformatf("t1_din%0d", i),  din1,  exp_a[i]);
         check($sformatf("t1_fs%0d", i),   fs1,   (i == 0));
         check($sformatf("t1_fe%0d", i),   fe1,   (i == 3));
         check($sformatf("t1_busy%0d", i), busy1, 1);
         tick();
      end
      check("t1_done", done1, 1);
      check("t1_en_off", en1, 0);
      check("t1_busy_off", busy1, 0);
      check("t1_rmax", rmax1, 12'hD00);
      check("t1_cnt", cnt1, 4);
      tick();
      check("t1_done_once", done1, 0);
      check("t1_rmax_hold", rmax1, 12'hD00);

      // Test 2: DIV=2, sample every other cycle, DataIn holds between
      start_frame(1'b1, 16'h0001, 10'd4);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("t2_en%0d", k),  en2,  (k % 2 == 0));
         check($sformatf("t2_din%0d", k), din2, exp_a[k / 2]);
         check($sformatf("t2_fs%0d", k),  fs2,  (k == 0));
         check($sformatf("t2_fe%0d", k),  fe2,  (k == 6));
         tick();
      end
      check("t2_done", done2, 1);
      check("t2_rmax", rmax2, 12'hD00);
      check("t2_cnt", cnt2, 4);

      // Test 3: FrameLen=0 goes straight to DONE; RefMax cleared
      tick();
      start_frame(1'b0, 16'h0001, 10'd0);
      check("t3_en", en1, 0);
      check("t3_busy", busy1, 0);
      check("t3_done", done1, 1);
      check("t3_rmax", rmax1, 0);
      check("t3_cnt", cnt1, 0);
      tick();
      check("t3_done_once", done1, 0);
      check("t3_en_after", en1, 0);

      // Test 4: Stop during the second sample
      start_frame(1'b0, 16'h0001, 10'd8);
      check("t4_din0", din1, 12'h001);
      tick();
      check("t4_din1", din1, 12'h400);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t4_en", en1, 0);
      check("t4_busy", busy1, 0);
      check("t4_cnt", cnt1, 2);
      check("t4_rmax", rmax1, 12'h400);
      done_any = 1'b0;
      for (int i = 0; i < 3; i++) begin
         done_any |= done1 | en1;
         tick();
      end
      check("t4_no_done_no_en", done_any, 0);
      check("t4_cnt_hold", cnt1, 2);

      // Test 5: Seed=0 uses default; Start during RUN ignored
      start_frame(1'b0, 16'h0000, 10'd3);
      check("t5_din0", din1, exp_c[0]);
      tick();
      check("t5_din1", din1, exp_c[1]);
      start_frame(1'b0, 16'h0001, 10'd8);
      check("t5_din2", din1, exp_c[2]);
      check("t5_fe", fe1, 1);
      tick();
      check("t5_done", done1, 1);
      check("t5_rmax", rmax1, 12'hCE1);
      check("t5_cnt", cnt1, 3);
      tick();
      seed = 16'h0001; frame_len = 10'd4;
      start1 = 1'b1; stop = 1'b1;
      tick();
      start1 = 1'b0; stop = 1'b0;
      check("t5_ss_en", en1, 0);
      check("t5_ss_busy", busy1, 0);
      tick();
      check("t5_ss_done", done1, 0);
      check("t5_ss_rmax_hold", rmax1, 12'hCE1);

      // Test 6: reset mid-frame, then a 1000-sample frame checked against a model
      start_frame(1'b0, 16'h0001, 10'd8);
      tick();
      synrst = 1'b0;
      tick();
      check("t6_rst_en",   en1,   0);
      check("t6_rst_din",  din1,  0);
      check("t6_rst_busy", busy1, 0);
      check("t6_rst_rmax", rmax1, 0);
      check("t6_rst_cnt",  cnt1,  0);
      check("t6_rst_fe",   fe1,   0);
      synrst = 1'b1;
      tick();

      l = 16'h1234; m_max = '0; m_sum = '0;
      for (int i = 0; i < 1000; i++) begin
         if (l[11:0] > m_max) m_max = l[11:0];
         m_sum += 32'(l[11:0]);
         l = model_next(l);
      end

      start_frame(1'b0, 16'h1234, 10'd1000);
      o_max = '0; o_sum = '0; seen = 0; got_done = 1'b0;
      for (int c = 0; c < 1100; c++) begin
         if (done1) begin
            got_done = 1'b1;
            break;
         end
         if (en1) begin
            seen++;
            o_sum += 32'(din1);
            if (din1 > o_max) o_max = din1;
         end
         tick();
      end
      check("t6_done_seen", got_done, 1);
      check("t6_count", seen, 1000);
      check("t6_sum", o_sum, m_sum);
      check("t6_sorter_max", o_max, m_max);
      check("t6_rmax", rmax1, m_max);
      check("t6_cnt", cnt1, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
